clk_phase_sched: RTL and testbench
==================================

# clk_phase_sched

Synthesizable clock-enable scheduler for the template-matching datapath. It divides the single system clock into a programmable tick rate and distributes those ticks as a rotating one-hot phase enable across the datapath stages. Supported modes: free-running, graceful stop, and single-step. It sits directly after the clock source and is the only block that decides when datapath stages advance; no stage gates the clock itself.

## Interface
- DIV_W, 8: width of divide-ratio configuration.
- PHASES, 4: number of datapath phases; power of two, ≥2.
- CNT_W, 16: width of the tick counter.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_div  in  DIV_W  divide ratio; a tick is issued every cfg_div+1 clocks.
- cfg_load  in  1  latch cfg_div into div_reg; honoured only in IDLE.
- run  in  1  level; request free-running ticks.
- step_req  in  1  one-cycle pulse; request one full phase sequence.
- step_ack  out  1  one-cycle pulse when a step sequence completes.
- tick  out  1  one-cycle enable, registered.
- phase  out  log2(PHASES)  index of the phase that the current tick belongs to.
- phase_en  out  PHASES  one-hot; equals 1<<phase while tick=1, else 0.
- busy  out  1  high in any state other than IDLE.
- tick_cnt  out  CNT_W  ticks issued since reset; wraps modulo 2^CNT_W.

## Operation
- Registers: div_reg (reset 0), div_cnt (reset 0), phase (reset 0), tick_cnt (reset 0), state (reset IDLE).
- Reset values of outputs: tick=0, phase_en=0, phase=0, step_ack=0, busy=0, tick_cnt=0.
- States:
  - IDLE
    - run=1 → RUN.
    - Else step_req=1 → STEP.
    - run has priority when both are asserted in the same cycle.
    - div_cnt is cleared on entry to IDLE.
  - RUN
    - div_cnt increments each clock.
    - When div_cnt==div_reg: tick=1 next cycle, div_cnt←0, phase←phase+1 (wraps PHASES-1→0).
    - run=0 → STOP.
  - STOP
    - Continues ticking exactly as RUN until the tick with phase==PHASES-1 is issued, then → IDLE.
    - If phase==0 and no partial sequence is in progress when run falls, go directly to IDLE.
    - run re-asserted while in STOP → RUN, with no glitch in tick spacing.
  - STEP
    - Ticks as RUN until the tick for phase PHASES-1 has been issued.
    - On the cycle after that tick: step_ack=1, → IDLE.
    - run and step_req are ignored in STEP.
- Configuration:
  - cfg_load outside IDLE is ignored; div_reg is unchanged.
  - cfg_load and a run/step request in the same IDLE cycle: load takes effect first, so the new ratio governs the first tick.
- Counting: tick_cnt increments on every tick and wraps silently.
- Reset mid-operation: all registers return to their reset values immediately (asynchronous); no step_ack is issued for an aborted step.

## Timing
- tick, phase, phase_en and step_ack are registered outputs; no combinational path from inputs to outputs.
- First tick after entering RUN or STEP appears on the (div_reg+1)-th clock after the state change.
- Ticks are spaced exactly div_reg+1 clocks apart.
- div_reg=0: a tick on every clock; phase cycles 0,1,…,PHASES-1,0.
- Phase sequence always starts at 0 after IDLE, because phase is only ever left at 0 on exit to IDLE.
- step_ack follows the last phase tick by 1 clock. busy drops in the same cycle step_ack is high.
- Minimum STEP duration: PHASES×(div_reg+1)+1 clocks.

## Structure
- Shared package `clk_sched_pkg`: state encoding (IDLE, RUN, STOP, STEP) and default DIV_W/PHASES/CNT_W constants.
- One natural sub-module, `tick_divider`:
  - Ports: div_cnt, div_reg compare, clear input, tick output.
  - Instantiated once; the FSM, phase counter and tick counter stay in the top module.

## Test plan
- Reset, cfg_div=3, cfg_load, run=1 → first tick 4 clocks after entering RUN; subsequent ticks every 4 clocks; phase_en sequence 0001,0010,0100,1000,0001.
- cfg_div=0, step_req pulse → 4 consecutive ticks (phases 0–3), step_ack 1 clock later, busy=0 in that same cycle, tick_cnt=4.
- div=1, run=1, drop run just after the phase-1 tick → ticks for phases 2 and 3 still issued, then IDLE; phase=0.
- cfg_load with cfg_div=7 while in RUN at div=2 → spacing stays 3 clocks; after returning to IDLE, the load is accepted.
- Assert rst while in STEP after 2 ticks → all outputs 0 immediately; no step_ack; a subsequent step_req produces a full 4-tick sequence starting at phase 0.
- run and step_req asserted in the same IDLE cycle → RUN entered, no step_ack ever issued; tick_cnt wraps 0xFFFF→0 without disturbing phase.

Source files
------------

// File: rtl/clk_sched_pkg.sv
// clk_sched_pkg: shared definitions for the clock-enable scheduler.
//   - state_e   : scheduler FSM encoding
//   - *_DEF     : default widths / phase count used by the modules
package clk_sched_pkg;

  localparam int DIV_W_DEF  = 8;
  localparam int PHASES_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2,
    ST_STEP = 2'd3
  } state_e;

endpackage

// File: rtl/tick_divider.sv
// tick_divider: programmable clock divider for the phase scheduler.
//   clk, rst    : system clock, async active-high reset
//   en_i        : count while high (scheduler not idle)
//   clr_i       : synchronous clear of the divide counter (wins over en_i)
//   div_reg_i   : latched divide ratio; hit every div_reg_i+1 enabled clocks
//   hit_o       : combinational, counter has reached the ratio this cycle
module tick_divider
  import clk_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_reg_i,
  output logic             hit_o
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  assign hit_o = en_i && (div_cnt_q == div_reg_i);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr_i)     div_cnt_d = '0;
    else if (en_i) div_cnt_d = hit_o ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/clk_phase_sched.sv
// clk_phase_sched: divides the system clock into a programmable tick rate and
// hands each tick to one datapath phase in rotation (one-hot phase_en).
//   clk, rst     : system clock, async active-high reset
//   cfg_div_i    : divide ratio, tick every cfg_div_i+1 clocks
//   cfg_load_i   : latch cfg_div_i; only honoured while idle
//   run_i        : level, free-running ticks while high (graceful stop on fall)
//   step_req_i   : pulse, run exactly one full phase sequence
//   step_ack_o   : pulse, one clock after the last tick of a step
//   tick_o       : registered tick enable
//   phase_o      : phase index of the current tick
//   phase_en_o   : one-hot phase enable, zero when no tick
//   busy_o       : scheduler not idle
//   tick_cnt_o   : ticks issued since reset, wrapping
module clk_phase_sched
  import clk_sched_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int PHASES = PHASES_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIV_W-1:0]          cfg_div_i,
  input  logic                      cfg_load_i,
  input  logic                      run_i,
  input  logic                      step_req_i,
  output logic                      step_ack_o,
  output logic                      tick_o,
  output logic [$clog2(PHASES)-1:0] phase_o,
  output logic [PHASES-1:0]         phase_en_o,
  output logic                      busy_o,
  output logic [CNT_W-1:0]          tick_cnt_o
);

  localparam int PH_W = $clog2(PHASES);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_reg_q, div_reg_d;
  logic [PH_W-1:0]     phase_q, phase_d, ph_next;
  logic [PHASES-1:0]   phase_en_q, phase_en_d;
  logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic                tick_q, tick_d;
  logic                ack_q, ack_d;
  logic                hit, div_en, div_clr, issue;

  // Divider runs in every non-idle state and is parked at zero whenever the
  // FSM is (or is about to be) idle, so each RUN/STEP entry starts a full period.
  assign div_en  = (state_q != ST_IDLE);
  assign div_clr = (state_d == ST_IDLE);

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .en_i      (div_en),
    .clr_i     (div_clr),
    .div_reg_i (div_reg_q),
    .hit_o     (hit)
  );

  // phase_q names the phase of the tick currently on tick_o; it moves on the
  // edge after that tick, so ph_next is the phase the next tick will carry.
  // PHASES is a power of two, so the +1 wraps naturally.
  assign ph_next = tick_q ? phase_q + 1'b1 : phase_q;

  always_comb begin
    state_d   = state_q;
    div_reg_d = div_reg_q;
    ack_d     = 1'b0;
    issue     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // load lands on the same edge as the state change, so a same-cycle
        // request already runs at the new ratio
        if (cfg_load_i) div_reg_d = cfg_div_i;
        if (run_i)           state_d = ST_RUN;
        else if (step_req_i) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (!run_i && ph_next == '0) begin
          // sequence boundary: nothing partial to finish
          state_d = ST_IDLE;
        end else begin
          issue = hit;
          if (!run_i) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (run_i) begin
          // divider keeps its count, so spacing is undisturbed
          state_d = ST_RUN;
          issue   = hit;
        end else if (ph_next == '0) begin
          // last-phase tick is on tick_o now; suppress a div=0 follow-on
          state_d = ST_IDLE;
        end else begin
          issue = hit;
        end
      end
      ST_STEP: begin
        if (tick_q && phase_q == PH_LAST) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
        end else begin
          issue = hit;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tick_d     = issue;
    phase_d    = ph_next;
    phase_en_d = issue ? ({{(PHASES-1){1'b0}}, 1'b1} << ph_next) : '0;
    tick_cnt_d = tick_cnt_q + {{(CNT_W-1){1'b0}}, issue};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      div_reg_q  <= '0;
      phase_q    <= '0;
      phase_en_q <= '0;
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_reg_q  <= div_reg_d;
      phase_q    <= phase_d;
      phase_en_q <= phase_en_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
    end
  end

  assign tick_o     = tick_q;
  assign phase_o    = phase_q;
  assign phase_en_o = phase_en_q;
  assign step_ack_o = ack_q;
  assign tick_cnt_o = tick_cnt_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_phase_sched.sv
module tb_clk_phase_sched;

  localparam int DIV_W  = 8;
  localparam int PHASES = 4;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic              cfg_load = 1'b0;
  logic              run = 1'b0;
  logic              step_req = 1'b0;
  logic              step_ack_o, tick_o, busy_o;
  logic [1:0]        phase_o;
  logic [PHASES-1:0] phase_en_o;
  logic [CNT_W-1:0]  tick_cnt_o;

  clk_phase_sched #(.DIV_W(DIV_W), .PHASES(PHASES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_div_i  (cfg_div),
    .cfg_load_i (cfg_load),
    .run_i      (run),
    .step_req_i (step_req),
    .step_ack_o (step_ack_o),
    .tick_o     (tick_o),
    .phase_o    (phase_o),
    .phase_en_o (phase_en_o),
    .busy_o     (busy_o),
    .tick_cnt_o (tick_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int ph; } tick_exp_t;
  typedef struct { int div; int ndrop; int total; } run_vec_t;
  typedef struct { int div; int ack_dly; } step_vec_t;

  tick_exp_t tq[$];
  int        aq[$];
  int        n_cmp = 0, n_bad = 0;
  int        exp_cnt = 0;
  bit        tick_chk = 1'b1;
  tick_exp_t e;
  int        a;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // scoreboard: every tick / ack the DUT produces is matched against the queue
  always @(negedge clk) begin
    if (tick_chk) begin
      if (tick_o) begin
        if (tq.size() == 0) chk("tick_unexpected", tick_o, 0);
        else begin
          e = tq.pop_front();
          chk("tick_cyc", cyc, e.cyc);
          chk("tick_phase", phase_o, e.ph);
          chk("tick_phase_en", phase_en_o, 64'(1) << e.ph);
        end
      end else if (phase_en_o != '0) begin
        chk("phase_en_no_tick", phase_en_o, 0);
      end
    end
    if (step_ack_o) begin
      if (aq.size() == 0) chk("ack_unexpected", step_ack_o, 0);
      else begin
        a = aq.pop_front();
        chk("ack_cyc", cyc, a);
        chk("ack_busy", busy_o, 0);
      end
    end
  end

  task automatic go_edge();
    @(posedge clk); #2;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) go_edge();
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_phase"}, phase_o, 0);
    chk({tag, "_phase_en"}, phase_en_o, 0);
    chk({tag, "_tick_cnt"}, tick_cnt_o, exp_cnt);
    chk({tag, "_tq_left"}, tq.size(), 0);
    chk({tag, "_aq_left"}, aq.size(), 0);
  endtask

  // free-run at div, drop run once tick ndrop is visible; total ticks expected
  task automatic run_seq(input run_vec_t v, input bit hammer);
    int c0, d1;
    cfg_div = DIV_W'(v.div); cfg_load = 1'b1; run = 1'b1;
    c0 = cyc + 1; d1 = v.div + 1;
    for (int k = 1; k <= v.total; k++) tq.push_back('{cyc: c0 + k*d1, ph: (k-1) % PHASES});
    go_edge();
    chk("run_busy", busy_o, 1);
    if (hammer) cfg_div = 8'd7;   // keep loading a different ratio while running
    else        cfg_load = 1'b0;
    wait_to(c0 + v.ndrop*d1);
    run = 1'b0; cfg_load = 1'b0;
    exp_cnt += v.total;
    wait_to(c0 + v.total*d1 + 3);
    idle_checks("run_end");
  endtask

  task automatic do_step(input step_vec_t v, input bit load);
    int c0, d1;
    if (load) begin cfg_div = DIV_W'(v.div); cfg_load = 1'b1; end
    step_req = 1'b1;
    c0 = cyc + 1; d1 = v.div + 1;
    for (int k = 1; k <= PHASES; k++) tq.push_back('{cyc: c0 + k*d1, ph: k-1});
    aq.push_back(c0 + v.ack_dly);
    go_edge();
    step_req = 1'b0; cfg_load = 1'b0;
    chk("step_busy", busy_o, 1);
    go_edge();
    run = 1'b1; step_req = 1'b1;   // must be ignored while stepping
    go_edge();
    run = 1'b0; step_req = 1'b0;
    exp_cnt += PHASES;
    wait_to(c0 + v.ack_dly + 3);
    idle_checks("step_end");
  endtask

  run_vec_t  rv[5];
  step_vec_t sv[3];

  initial begin
    int c0, k1;
    rv[0] = '{div: 3, ndrop: 5, total: 8};
    rv[1] = '{div: 1, ndrop: 2, total: 4};
    rv[2] = '{div: 0, ndrop: 4, total: 4};
    rv[3] = '{div: 2, ndrop: 7, total: 8};
    rv[4] = '{div: 0, ndrop: 1, total: 4};
    sv[0] = '{div: 0, ack_dly: 5};
    sv[1] = '{div: 1, ack_dly: 9};
    sv[2] = '{div: 3, ack_dly: 17};

    // reset state
    repeat (3) go_edge();
    chk("rst_tick", tick_o, 0);
    chk("rst_phase_en", phase_en_o, 0);
    chk("rst_phase", phase_o, 0);
    chk("rst_ack", step_ack_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_tick_cnt", tick_cnt_o, 0);
    rst = 1'b0;
    repeat (2) go_edge();

    foreach (rv[i]) begin run_seq(rv[i], 1'b0); go_edge(); end
    foreach (sv[i]) begin do_step(sv[i], 1'b1); go_edge(); end

    // cfg_load while running is ignored; a load in IDLE is accepted
    run_seq('{div: 2, ndrop: 3, total: 4}, 1'b1);
    cfg_div = 8'd7; cfg_load = 1'b1;
    go_edge();
    cfg_load = 1'b0;
    do_step('{div: 7, ack_dly: 33}, 1'b0);

    // reset in the middle of a step
    cfg_div = 8'd1; cfg_load = 1'b1; step_req = 1'b1;
    c0 = cyc + 1;
    tq.push_back('{cyc: c0 + 2, ph: 0});
    tq.push_back('{cyc: c0 + 4, ph: 1});
    go_edge();
    cfg_load = 1'b0; step_req = 1'b0;
    wait_to(c0 + 4);
    #4 rst = 1'b1;
    #1;
    chk("mrst_tick", tick_o, 0);
    chk("mrst_phase_en", phase_en_o, 0);
    chk("mrst_phase", phase_o, 0);
    chk("mrst_ack", step_ack_o, 0);
    chk("mrst_busy", busy_o, 0);
    chk("mrst_tick_cnt", tick_cnt_o, 0);
    chk("mrst_tq_left", tq.size(), 0);
    exp_cnt = 0;
    go_edge(); go_edge();
    rst = 1'b0;
    repeat (12) go_edge();   // no late ack may appear
    do_step('{div: 0, ack_dly: 5}, 1'b0);   // div_reg back at 0
    go_edge();

    // run and step together -> RUN; tick_cnt wrap
    run = 1'b1; step_req = 1'b1;
    go_edge();
    c0 = cyc;
    step_req = 1'b0;
    chk("prio_busy", busy_o, 1);
    tick_chk = 1'b0;
    k1 = 65535 - exp_cnt;
    wait_to(c0 + k1);
    chk("wrap_pre_cnt", tick_cnt_o, 16'hFFFF);
    chk("wrap_pre_phase", phase_o, (k1 - 1) % PHASES);
    go_edge();
    chk("wrap_cnt", tick_cnt_o, 0);
    chk("wrap_tick", tick_o, 1);
    chk("wrap_phase", phase_o, k1 % PHASES);
    run = 1'b0;
    repeat (8) go_edge();
    chk("wrap_end_busy", busy_o, 0);
    chk("wrap_end_phase", phase_o, 0);
    chk("end_aq_left", aq.size(), 0);
    chk("end_tq_left", tq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
